// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the icache/dcache memory bus arbiter: bus commands, tag owners
// and owner-table entries.
package mem_bus_arbiter_pkg;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef enum logic {
      OWN_ICACHE = 1'b0,
      OWN_DCACHE = 1'b1
   } MEM_OWNER;

   typedef struct packed {
      logic     valid;
      MEM_OWNER owner;
   } MEM_TAG_ENTRY;

   localparam MEM_TAG_ENTRY ENTRY_EMPTY = '{valid: 1'b0, owner: OWN_ICACHE};

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Cache-side, memory-side and status signals of the arbiter, grouped as one bundle.
interface mem_bus_arbiter_if #(
   parameter int unsigned TAG_W = 4
);
   import mem_bus_arbiter_pkg::*;

   BUS_COMMAND          icache2mem_command;
   logic [ADDR_W-1:0]   icache2mem_addr;
   BUS_COMMAND          dcache2mem_command;
   logic [ADDR_W-1:0]   dcache2mem_addr;
   logic [DATA_W-1:0]   dcache2mem_data;
   logic [TAG_W-1:0]    mem2proc_response;
   logic [DATA_W-1:0]   mem2proc_data;
   logic [TAG_W-1:0]    mem2proc_tag;

   BUS_COMMAND          proc2mem_command;
   logic [ADDR_W-1:0]   proc2mem_addr;
   logic [DATA_W-1:0]   proc2mem_data;
   logic [TAG_W-1:0]    mem2icache_response;
   logic [DATA_W-1:0]   mem2icache_data;
   logic [TAG_W-1:0]    mem2icache_tag;
   logic [TAG_W-1:0]    mem2dcache_response;
   logic [DATA_W-1:0]   mem2dcache_data;
   logic [TAG_W-1:0]    mem2dcache_tag;
   logic [TAG_W-1:0]    icache_inflight;
   logic [TAG_W-1:0]    dcache_inflight;
   logic                tag_err;

   modport slave (
      input  icache2mem_command, icache2mem_addr,
      input  dcache2mem_command, dcache2mem_addr, dcache2mem_data,
      input  mem2proc_response, mem2proc_data, mem2proc_tag,
      output proc2mem_command, proc2mem_addr, proc2mem_data,
      output mem2icache_response, mem2icache_data, mem2icache_tag,
      output mem2dcache_response, mem2dcache_data, mem2dcache_tag,
      output icache_inflight, dcache_inflight, tag_err
   );

   modport master (
      output icache2mem_command, icache2mem_addr,
      output dcache2mem_command, dcache2mem_addr, dcache2mem_data,
      output mem2proc_response, mem2proc_data, mem2proc_tag,
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
      input  mem2icache_response, mem2icache_data, mem2icache_tag,
      input  mem2dcache_response, mem2dcache_data, mem2dcache_tag,
      input  icache_inflight, dcache_inflight, tag_err
   );

endinterface

// File: rtl/mem_bus_arbiter_tag_table.sv
// Owner table for in-flight load tags: set on accept, clear on return (set wins),
// with registered per-owner occupancy counts.
module mem_tag_table
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned TAG_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_set_en,
   input  logic [TAG_W-1:0] i_set_tag,
   input  MEM_OWNER         i_set_owner,
   input  logic             i_clr_en,
   input  logic [TAG_W-1:0] i_clr_tag,
   output logic             o_set_valid_c,
   output MEM_TAG_ENTRY     o_clr_entry_c,
   output logic [TAG_W-1:0] o_icache_cnt,
   output logic [TAG_W-1:0] o_dcache_cnt
);

   localparam int unsigned NUM_TAGS = 2 ** TAG_W;

   MEM_TAG_ENTRY     r_table     [NUM_TAGS];
   MEM_TAG_ENTRY     w_table_nxt [NUM_TAGS];
   logic [TAG_W-1:0] r_icache_cnt;
   logic [TAG_W-1:0] r_dcache_cnt;
   logic [TAG_W-1:0] w_icache_cnt_nxt;
   logic [TAG_W-1:0] w_dcache_cnt_nxt;

   always_comb begin
      o_set_valid_c = r_table[i_set_tag].valid;
      o_clr_entry_c = r_table[i_clr_tag];
   end

   // Tag 0 means "none" and is never written, so it is skipped in the counts.
   always_comb begin
      w_table_nxt      = r_table;
      w_icache_cnt_nxt = '0;
      w_dcache_cnt_nxt = '0;
      if (i_clr_en && (i_clr_tag != '0)) begin
         w_table_nxt[i_clr_tag] = ENTRY_EMPTY;
      end
      if (i_set_en && (i_set_tag != '0)) begin
         w_table_nxt[i_set_tag] = '{valid: 1'b1, owner: i_set_owner};
      end
      for (int unsigned i = 1; i < NUM_TAGS; i++) begin
         if (w_table_nxt[i].valid) begin
            if (w_table_nxt[i].owner == OWN_ICACHE) begin
               w_icache_cnt_nxt = w_icache_cnt_nxt + TAG_W'(1);
            end else begin
               w_dcache_cnt_nxt = w_dcache_cnt_nxt + TAG_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            r_table[i] <= ENTRY_EMPTY;
         end
         r_icache_cnt <= '0;
         r_dcache_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            r_table[i] <= w_table_nxt[i];
         end
         r_icache_cnt <= w_icache_cnt_nxt;
         r_dcache_cnt <= w_dcache_cnt_nxt;
      end
   end

   assign o_icache_cnt = r_icache_cnt;
   assign o_dcache_cnt = r_dcache_cnt;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the tagged memory bus between icache and dcache: same-cycle grant with
// icache anti-starvation, and steers returning tags back to the requester that owns them.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned TAG_W        = 4,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic             clock,
   input  logic             reset,
   mem_bus_arbiter_if.slave bus
);

   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic [STARVE_W-1:0] r_starve_cnt;
   logic [STARVE_W-1:0] w_starve_nxt;
   logic                r_tag_err;
   logic                w_ic_req;
   logic                w_dc_req;
   logic                w_grant_ic;
   logic                w_grant_dc;
   BUS_COMMAND          w_cmd;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_data;
   logic                w_set_en;
   MEM_OWNER            w_set_owner;
   logic                w_clr_en;
   logic                w_set_valid;
   MEM_TAG_ENTRY        w_clr_entry;
   logic                w_err;
   logic [TAG_W-1:0]    w_icache_cnt;
   logic [TAG_W-1:0]    w_dcache_cnt;

   // Requests are masked during reset so nothing reaches memory or the table.
   always_comb begin
      w_ic_req   = reset && (bus.icache2mem_command != BUS_NONE);
      w_dc_req   = reset && (bus.dcache2mem_command != BUS_NONE);
      w_grant_ic = w_ic_req && (!w_dc_req || (r_starve_cnt == STARVE_W'(STARVE_LIMIT)));
      w_grant_dc = w_dc_req && !w_grant_ic;
   end

   always_comb begin
      w_cmd  = BUS_NONE;
      w_addr = '0;
      w_data = '0;
      if (w_grant_ic) begin
         w_cmd  = bus.icache2mem_command;
         w_addr = bus.icache2mem_addr;
      end else if (w_grant_dc) begin
         w_cmd  = bus.dcache2mem_command;
         w_addr = bus.dcache2mem_addr;
         w_data = bus.dcache2mem_data;
      end
   end

   always_comb begin
      w_set_en    = (bus.mem2proc_response != '0) && (w_cmd == BUS_LOAD);
      w_set_owner = w_grant_ic ? OWN_ICACHE : OWN_DCACHE;
      w_clr_en    = reset && (bus.mem2proc_tag != '0);
      // A same-cycle return frees the tag first, so re-accepting it is legal.
      w_err       = (w_clr_en && !w_clr_entry.valid) ||
                    (w_set_en && w_set_valid &&
                     !(w_clr_en && (bus.mem2proc_tag == bus.mem2proc_response)));
   end

   always_comb begin
      if (w_grant_dc && w_ic_req) begin
         w_starve_nxt = (r_starve_cnt == STARVE_W'(STARVE_LIMIT)) ? r_starve_cnt
                                                                  : r_starve_cnt + STARVE_W'(1);
      end else begin
         w_starve_nxt = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_starve_cnt <= '0;
         r_tag_err    <= 1'b0;
      end else begin
         r_starve_cnt <= w_starve_nxt;
         r_tag_err    <= r_tag_err | w_err;
      end
   end

   mem_tag_table #(
      .TAG_W (TAG_W)
   ) u_tag_table (
      .clock         (clock),
      .reset         (reset),
      .i_set_en      (w_set_en),
      .i_set_tag     (bus.mem2proc_response),
      .i_set_owner   (w_set_owner),
      .i_clr_en      (w_clr_en),
      .i_clr_tag     (bus.mem2proc_tag),
      .o_set_valid_c (w_set_valid),
      .o_clr_entry_c (w_clr_entry),
      .o_icache_cnt  (w_icache_cnt),
      .o_dcache_cnt  (w_dcache_cnt)
   );

   always_comb begin
      bus.proc2mem_command    = w_cmd;
      bus.proc2mem_addr       = w_addr;
      bus.proc2mem_data       = w_data;
      bus.mem2icache_response = w_grant_ic ? bus.mem2proc_response : '0;
      bus.mem2dcache_response = w_grant_dc ? bus.mem2proc_response : '0;
      bus.mem2icache_data     = bus.mem2proc_data;
      bus.mem2dcache_data     = bus.mem2proc_data;
      bus.mem2icache_tag      = '0;
      bus.mem2dcache_tag      = '0;
      if (w_clr_en && w_clr_entry.valid) begin
         if (w_clr_entry.owner == OWN_ICACHE) begin
            bus.mem2icache_tag = bus.mem2proc_tag;
         end else begin
            bus.mem2dcache_tag = bus.mem2proc_tag;
         end
      end
      bus.icache_inflight = w_icache_cnt;
      bus.dcache_inflight = w_dcache_cnt;
      bus.tag_err         = r_tag_err;
   end

endmodule
